// File: rtl/vec_mem_pkg.sv
// Shared types for the vector memory responder: lane/vector/address types and FSM states.
package vec_mem_pkg;

    localparam int LANES = 3;
    localparam int WIDTH = 18;
    localparam int AW    = 10;

    typedef logic [WIDTH-1:0] lane_t;
    typedef lane_t [LANES-1:0] vec_t;
    typedef logic [AW-1:0]    addr_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        RESP
    } state_t;

endpackage

// File: rtl/vec_mem_responder.sv
// Serialises a 3-lane vector load/store onto a single-port synchronous-read memory
// and returns the assembled read vector with a one-cycle response pulse.
module vec_mem_responder #(
    parameter int WIDTH = vec_mem_pkg::WIDTH,
    parameter int LANES = vec_mem_pkg::LANES,
    parameter int AW    = vec_mem_pkg::AW,
    parameter int DEPTH = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    input  logic                          req_we,
    input  logic [AW-1:0]                 A1,
    input  logic [AW-1:0]                 A2,
    input  logic [AW-1:0]                 A3,
    input  logic [LANES-1:0][WIDTH-1:0]   wdata,
    output logic                          stall,
    output logic                          busy,
    output logic                          rsp_valid,
    output logic [LANES-1:0][WIDTH-1:0]   rdata,
    output logic [LANES-1:0]              oob,
    output logic [AW-1:0]                 mem_addr,
    output logic                          mem_we,
    output logic [WIDTH-1:0]              mem_wdata,
    input  logic [WIDTH-1:0]              mem_rdata
);
    import vec_mem_pkg::*;

    localparam logic [1:0] LAST = 2'(LANES - 1);

    state_t                        r_state;
    logic [1:0]                    r_idx;
    logic                          r_we;
    logic                          r_rsp;
    logic [LANES-1:0][AW-1:0]      r_addr;
    logic [LANES-1:0][WIDTH-1:0]   r_wdata;
    logic [LANES-1:0][WIDTH-1:0]   r_rdata;
    logic [LANES-1:0]              r_oob;
    logic [AW-1:0]                 r_mem_addr;
    logic                          r_mem_we;
    logic [WIDTH-1:0]              r_mem_wdata;

    logic [LANES-1:0][AW-1:0]      w_req_addr;
    logic [LANES-1:0]              w_req_oob;
    logic [1:0]                    w_nxt_idx;
    logic [1:0]                    w_cap_idx;
    logic [WIDTH-1:0]              w_cap_data;

    function automatic logic out_of_range(input logic [AW-1:0] a);
        return {{(32-AW){1'b0}}, a} >= 32'(DEPTH);
    endfunction

    assign w_req_addr = {A3, A2, A1};
    assign w_nxt_idx  = r_idx + 2'd1;

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            w_req_oob[k] = out_of_range(w_req_addr[k]);
        end
    end

    // Read data lags its address by one cycle, so the lane being captured is the previous slot.
    always_comb begin
        w_cap_idx  = (r_state == DRAIN) ? LAST : (r_idx - 2'd1);
        w_cap_data = mem_rdata;
        if (w_cap_idx <= LAST && r_oob[w_cap_idx]) begin
            w_cap_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_rsp       <= 1'b0;
            r_oob       <= '0;
            r_rdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
        end else begin
            r_rsp       <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_addr      <= w_req_addr;
                        r_wdata     <= wdata;
                        r_we        <= req_we;
                        r_oob       <= w_req_oob;
                        r_idx       <= '0;
                        r_state     <= ISSUE;
                        r_mem_addr  <= A1;
                        r_mem_we    <= req_we & ~w_req_oob[0];
                        r_mem_wdata <= wdata[0];
                    end
                end
                ISSUE: begin
                    if (!r_we && r_idx != 2'd0) begin
                        r_rdata[w_cap_idx] <= w_cap_data;
                    end
                    if (r_idx == LAST) begin
                        r_state <= r_we ? RESP : DRAIN;
                        r_rsp   <= r_we;
                    end else begin
                        r_idx       <= w_nxt_idx;
                        r_mem_addr  <= r_addr[w_nxt_idx];
                        r_mem_we    <= r_we & ~r_oob[w_nxt_idx];
                        r_mem_wdata <= r_wdata[w_nxt_idx];
                    end
                end
                DRAIN: begin
                    r_rdata[LAST] <= w_cap_data;
                    r_state       <= RESP;
                    r_rsp         <= 1'b1;
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign rsp_valid = r_rsp;
    assign stall     = (req_valid | busy) & ~r_rsp;
    assign rdata     = r_rdata;
    assign oob       = r_oob;
    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;

endmodule
